// File: rtl/pwm_pulse_capture.sv
// pwm_pulse_capture: measures RC PWM high-pulse width in microseconds with glitch filtering, range check and loss timeout
module pwm_pulse_capture #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int FILTER_CYCLES = 4,
   parameter int MIN_US        = 500,
   parameter int MAX_US        = 2500,
   parameter int TIMEOUT_US    = 25000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pwm,
   output logic [15:0] o_pwm_value,
   output logic        o_pwm_ready,
   output logic        o_pwm_valid,
   output logic        o_timeout,
   output logic [7:0]  o_err_cnt
);
   localparam int DIV = CLK_FREQ / 1_000_000;
   localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
   localparam int FW  = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
   localparam int LW  = $clog2(TIMEOUT_US + 1);
   localparam logic [1:0] WAIT_LOW  = 2'd0;
   localparam logic [1:0] WAIT_RISE = 2'd1;
   localparam logic [1:0] MEASURE   = 2'd2;
   logic          sync1, sync2, filt, filt_d;
   logic [FW-1:0] flt_cnt;
   logic [1:0]    state;
   logic [PW-1:0] pres, us_pres;
   logic [15:0]   width, width_now;
   logic [LW-1:0] loss;
   logic          rise, fall, tick, us_tick, in_range, accept, reject, timeout_evt;
   // Synchronizer keeps sampling through reset so a pulse cut by reset still reads high afterwards.
   always_ff @(posedge i_clk) begin
      sync1 <= i_pwm;
      sync2 <= sync1;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         filt    <= 1'b0;
         filt_d  <= 1'b0;
         flt_cnt <= '0;
      end else begin
         filt_d <= filt;
         if (sync2 == filt)
            flt_cnt <= '0;
         else if (flt_cnt == FW'(FILTER_CYCLES - 1)) begin
            filt    <= sync2;
            flt_cnt <= '0;
         end else
            flt_cnt <= flt_cnt + FW'(1);
      end
   end
   always_comb begin
      rise        = filt & ~filt_d;
      fall        = ~filt & filt_d;
      tick        = (state == MEASURE) && (pres == PW'(DIV - 1));
      width_now   = width + 16'(tick);
      in_range    = (width_now >= 16'(MIN_US)) && (width_now <= 16'(MAX_US));
      accept      = (state == MEASURE) && fall && in_range;
      reject      = (state == MEASURE) && (fall ? !in_range : (tick && width == 16'(MAX_US)));
      us_tick     = us_pres == PW'(DIV - 1);
      timeout_evt = us_tick && (loss == LW'(TIMEOUT_US - 1));
   end
   // The falling-edge cycle is counted too, so the width is floor(high_cycles/DIV).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= WAIT_LOW;
         pres  <= '0;
         width <= '0;
      end else begin
         case (state)
            WAIT_LOW:  if (!filt && !sync2) state <= WAIT_RISE;
            WAIT_RISE: if (rise) begin
               state <= MEASURE;
               pres  <= '0;
               width <= '0;
            end
            MEASURE: begin
               if (fall)
                  state <= WAIT_RISE;
               else if (reject)
                  state <= WAIT_LOW;
               pres  <= tick ? '0 : pres + PW'(1);
               width <= width_now;
            end
            default: state <= WAIT_LOW;
         endcase
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         us_pres     <= '0;
         loss        <= '0;
         o_pwm_value <= '0;
         o_pwm_ready <= 1'b0;
         o_pwm_valid <= 1'b0;
         o_timeout   <= 1'b0;
         o_err_cnt   <= '0;
      end else begin
         us_pres     <= us_tick ? '0 : us_pres + PW'(1);
         loss        <= accept ? '0 : (us_tick && loss != LW'(TIMEOUT_US)) ? loss + LW'(1) : loss;
         o_pwm_ready <= accept;
         if (reject && o_err_cnt != 8'hFF)
            o_err_cnt <= o_err_cnt + 8'd1;
         if (accept) begin
            o_pwm_value <= width_now;
            o_pwm_valid <= 1'b1;
            o_timeout   <= 1'b0;
         end else if (timeout_evt) begin
            o_pwm_value <= '0;
            o_pwm_valid <= 1'b0;
            o_timeout   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pwm_pulse_capture.sv
// tb_pwm_pulse_capture: directed stimulus with a scoreboard of expected pulse widths, scaled to a 10 MHz clock
module tb_pwm_pulse_capture;
   localparam int CLK_FREQ = 10_000_000;
   localparam int DIV      = 10;
   localparam int MIN_US   = 50;
   localparam int MAX_US   = 250;
   localparam int TO_US    = 2500;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_pwm = 1'b0;
   logic [15:0] o_pwm_value;
   logic        o_pwm_ready, o_pwm_valid, o_timeout;
   logic [7:0]  o_err_cnt;
   int          checks = 0;
   int          errors = 0;
   int          exp_err = 0;
   logic [15:0] exp_q[$];
   always #5 i_clk = ~i_clk;
   pwm_pulse_capture #(
      .CLK_FREQ(CLK_FREQ), .FILTER_CYCLES(4), .MIN_US(MIN_US), .MAX_US(MAX_US), .TIMEOUT_US(TO_US)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pwm(i_pwm), .o_pwm_value(o_pwm_value),
      .o_pwm_ready(o_pwm_ready), .o_pwm_valid(o_pwm_valid), .o_timeout(o_timeout), .o_err_cnt(o_err_cnt)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask
   task automatic pulse(input int hi, input int lo);
      int w;
      w = hi / DIV;
      if (w >= MIN_US && w <= MAX_US) exp_q.push_back(16'(w));
      else exp_err = (exp_err == 255) ? 255 : exp_err + 1;
      i_pwm = 1'b1;
      tick(hi);
      i_pwm = 1'b0;
      tick(lo);
   endtask
   // Every ready strobe must match the oldest expected width.
   always @(negedge i_clk) begin
      if (o_pwm_ready) begin
         if (exp_q.size() == 0) check("unexpected_ready", 32'(o_pwm_ready), 0);
         else check("sb_value", 32'(o_pwm_value), 32'(exp_q.pop_front()));
      end
   end
   initial begin
      tick(5);
      check("rst_value", 32'(o_pwm_value), 0);
      check("rst_ready", 32'(o_pwm_ready), 0);
      check("rst_valid", 32'(o_pwm_valid), 0);
      check("rst_timeout", 32'(o_timeout), 0);
      check("rst_err", 32'(o_err_cnt), 0);
      i_rst = 1'b0;
      tick(10);
      exp_q.push_back(16'd150);
      i_pwm = 1'b1;
      tick(1500);
      i_pwm = 1'b0;
      tick(6);
      check("lat_before", 32'(o_pwm_ready), 0);
      tick();
      check("lat_at7", 32'(o_pwm_ready), 1);
      check("lat_value", 32'(o_pwm_value), 150);
      tick();
      check("lat_after", 32'(o_pwm_ready), 0);
      check("valid_150", 32'(o_pwm_valid), 1);
      check("err_150", 32'(o_err_cnt), 0);
      tick(30);
      pulse(300, 40);
      pulse(3000, 40);
      check("rej_err", 32'(o_err_cnt), 2);
      check("rej_value", 32'(o_pwm_value), 150);
      i_pwm = 1'b1;
      tick(2);
      i_pwm = 1'b0;
      tick(20);
      exp_q.push_back(16'd100);
      i_pwm = 1'b1;
      tick(500);
      i_pwm = 1'b0;
      tick(3);
      i_pwm = 1'b1;
      tick(497);
      i_pwm = 1'b0;
      tick(40);
      check("glitch_value", 32'(o_pwm_value), 100);
      check("glitch_err", 32'(o_err_cnt), 32'(exp_err));
      pulse(500, 40);
      check("min_value", 32'(o_pwm_value), 50);
      pulse(499, 40);
      pulse(2509, 40);
      check("max_value", 32'(o_pwm_value), 250);
      pulse(2510, 40);
      check("bound_err", 32'(o_err_cnt), 32'(exp_err));
      exp_q.push_back(16'd120);
      i_pwm = 1'b1;
      tick(1200);
      i_pwm = 1'b0;
      tick(24990);
      check("pre_to_timeout", 32'(o_timeout), 0);
      check("pre_to_valid", 32'(o_pwm_valid), 1);
      check("pre_to_value", 32'(o_pwm_value), 120);
      tick(40);
      check("to_timeout", 32'(o_timeout), 1);
      check("to_valid", 32'(o_pwm_valid), 0);
      check("to_value", 32'(o_pwm_value), 0);
      pulse(1800, 40);
      check("restore_value", 32'(o_pwm_value), 180);
      check("restore_valid", 32'(o_pwm_valid), 1);
      check("restore_timeout", 32'(o_timeout), 0);
      i_pwm = 1'b1;
      tick(1000);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      exp_err = 0;
      check("mid_rst_value", 32'(o_pwm_value), 0);
      check("mid_rst_ready", 32'(o_pwm_ready), 0);
      check("mid_rst_valid", 32'(o_pwm_valid), 0);
      check("mid_rst_timeout", 32'(o_timeout), 0);
      check("mid_rst_err", 32'(o_err_cnt), 0);
      tick(1000);
      i_pwm = 1'b0;
      tick(40);
      check("cut_pulse_value", 32'(o_pwm_value), 0);
      pulse(1500, 40);
      check("post_rst_value", 32'(o_pwm_value), 150);
      repeat (260) pulse(20, 20);
      check("err_sat", 32'(o_err_cnt), 32'(exp_err));
      repeat (5) pulse(20, 20);
      check("err_hold", 32'(o_err_cnt), 32'(exp_err));
      check("sat_value", 32'(o_pwm_value), 150);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pwm_pulse_capture.md
PWM_PULSE_CAPTURE -- requirements
Module: pwm_pulse_capture

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 100_000_000; clock frequency in Hz, giving DIV = CLK_FREQ/1_000_000 cycles per microsecond tick.
REQ-002 SHALL provide parameter FILTER_CYCLES, default 4; number of consecutive equal synchronized samples needed to change the filtered input.
REQ-003 SHALL provide parameter MIN_US, default 500; minimum accepted high-pulse width in microseconds.
REQ-004 SHALL provide parameter MAX_US, default 2500; maximum accepted high-pulse width in microseconds.
REQ-005 SHALL provide parameter TIMEOUT_US, default 25000; microseconds without an accepted pulse before signal loss is declared.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port i_pwm, input, 1 bit: asynchronous RC PWM input.
REQ-009 SHALL have port o_pwm_value, output, 16 bits: last accepted high-pulse width in microseconds.
REQ-010 SHALL have port o_pwm_ready, output, 1 bit: one-cycle strobe when o_pwm_value is updated.
REQ-011 SHALL have port o_pwm_valid, output, 1 bit: level, high while the signal is present.
REQ-012 SHALL have port o_timeout, output, 1 bit: level, high after signal loss.
REQ-013 SHALL have port o_err_cnt, output, 8 bits: saturating count of rejected pulses.

Function
REQ-014 SHALL pass i_pwm through a 2-flop synchronizer, then the glitch filter: filtered level changes only after FILTER_CYCLES consecutive synchronized samples differ from it.
REQ-015 SHALL derive rising and falling edges from the filtered level only; an edge strobe lasts one cycle.
REQ-016 SHALL implement FSM states WAIT_LOW, WAIT_RISE and MEASURE.
REQ-017 WAIT_LOW SHALL go to WAIT_RISE when the filtered level is 0; this discards any pulse already in progress.
REQ-018 WAIT_RISE SHALL go to MEASURE on a filtered rising edge, clearing the width counter and the prescaler in that cycle.
REQ-019 In MEASURE, the prescaler SHALL count 0..DIV-1 and emit a tick at DIV-1; each tick increments the width counter, so width = floor(high_cycles/DIV).
REQ-020 MEASURE SHALL handle a filtered falling edge as follows:
- MIN_US <= width <= MAX_US: latch o_pwm_value, strobe o_pwm_ready the next cycle, set o_pwm_valid=1, clear o_timeout.
- Otherwise: increment o_err_cnt.
- In both cases, go to WAIT_RISE.
REQ-021 MEASURE SHALL treat width reaching MAX_US+1 before any falling edge as an error: increment o_err_cnt and go to WAIT_LOW, with no value update.
REQ-022 o_err_cnt SHALL saturate at 8'hFF.
REQ-023 A free-running microsecond tick (independent of the FSM) SHALL drive a loss counter that is cleared on each accepted pulse and saturates at TIMEOUT_US.
REQ-024 When the loss counter reaches TIMEOUT_US, the block SHALL set o_pwm_valid=0, o_pwm_value=0 and o_timeout=1; o_timeout stays high until the next accepted pulse.
REQ-025 If an accepted pulse and the timeout occur in the same cycle, acceptance SHALL win: valid=1, timeout=0, and the loss counter clears.
REQ-026 Latency from the raw i_pwm falling edge to o_pwm_ready SHALL be 2 + FILTER_CYCLES + 1 cycles, fixed.
REQ-027 o_pwm_value SHALL change only on acceptance or on timeout; it stays stable between events.

Reset
REQ-028 While i_rst=1 at a clock edge, the block SHALL force o_pwm_value=0, o_pwm_ready=0, o_pwm_valid=0, o_timeout=0, o_err_cnt=0, FSM=WAIT_LOW, all counters 0, and filtered level 0.
REQ-029 Reset asserted mid-pulse SHALL discard that pulse; after release the FSM waits for a low level before the next measurement.

Verification (CLK_FREQ=100 MHz, defaults)
REQ-030 1500 us high pulse (150000 cycles), then low -> o_pwm_ready pulses once 7 cycles after the falling edge, o_pwm_value=1500, o_pwm_valid=1, o_err_cnt=0.
REQ-031 300 us pulse, then 3000 us pulse -> no ready strobe, o_err_cnt=2, o_pwm_value keeps its prior value.
REQ-032 2-cycle high glitch and 3-cycle low glitch inside a 1000 us pulse -> the glitches are ignored and o_pwm_value=1000.
REQ-033 Accept 1200 us, then hold i_pwm low for 25000 us -> o_timeout=1, o_pwm_valid=0, o_pwm_value=0; the next 1800 us pulse restores valid=1, timeout=0, value=1800.
REQ-034 Assert i_rst for 1 cycle mid-way through a 2000 us pulse -> all outputs are 0 and that pulse is not reported; the following 1500 us pulse reports 1500.
REQ-035 Send 260 rejected pulses -> o_err_cnt=8'hFF and holds at that value.
